// File: rtl/fn_sw_pkg.sv
// Shared encodings for the fn_sw_4 command sequencer and its golden model.
package fn_sw_pkg;

    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_XOR  = 2'b10,
        FN_XNOR = 2'b11
    } fn_sel_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EVAL = 2'b01,
        S_OUT  = 2'b10
    } state_e;

    // Field positions inside the 4-bit in_absel command.
    localparam int ABSEL_A      = 0;
    localparam int ABSEL_B      = 1;
    localparam int ABSEL_SEL_LO = 2;
    localparam int ABSEL_SEL_HI = 3;

    typedef struct packed {
        logic [1:0] sel;
        logic       b;
        logic       a;
    } cmd_t;

endpackage

// File: rtl/fn_sw_gold.sv
// Combinational reference for fn_sw_4: the expected y for a given a, b and sel.
module fn_sw_gold
    import fn_sw_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sel,
    output logic       y_exp
);

    always_comb begin
        y_exp = 1'b0;
        case (fn_sel_e'(sel))
            FN_AND:  y_exp = a & b;
            FN_OR:   y_exp = a | b;
            FN_XOR:  y_exp = a ^ b;
            FN_XNOR: y_exp = ~(a ^ b);
            default: y_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/fn_sw_seq.sv
// Command sequencer around fn_sw_4: issues a/b/sel, captures y one cycle later,
// cross-checks it against fn_sw_gold and packs PACK_W results per output word.
module fn_sw_seq
    import fn_sw_pkg::*;
#(
    parameter int PACK_W = 8,
    parameter int ERR_W  = 8,
    localparam int CW    = $clog2(PACK_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_absel,
    input  logic              flush,
    output logic              a,
    output logic              b,
    output logic [1:0]        sel,
    input  logic              y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] out_data,
    output logic [CW-1:0]     out_cnt,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [CW-1:0] FULL = CW'(PACK_W);

    state_e              state_q;
    cmd_t                cmd_q;
    cmd_t                cmd_d;
    logic [PACK_W-1:0]   res_q;
    logic [PACK_W-1:0]   res_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [PACK_W-1:0]   out_data_q;
    logic [CW-1:0]       out_cnt_q;
    logic [ERR_W-1:0]    err_q;
    logic                y_exp;

    // One operand register feeds both fn_sw_4 and the golden model, so the
    // two always see the same operands during S_EVAL.
    fn_sw_gold u_gold (
        .a     (cmd_q.a),
        .b     (cmd_q.b),
        .sel   (cmd_q.sel),
        .y_exp (y_exp)
    );

    always_comb begin
        cmd_d.a   = in_absel[ABSEL_A];
        cmd_d.b   = in_absel[ABSEL_B];
        cmd_d.sel = in_absel[ABSEL_SEL_HI:ABSEL_SEL_LO];
        res_d     = res_q | (PACK_W'(y) << cnt_q);
        cnt_d     = cnt_q + CW'(1);
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_cnt_q  <= '0;
            err_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A command takes priority; a coincident flush is dropped.
                    if (in_valid) begin
                        cmd_q   <= cmd_d;
                        state_q <= S_EVAL;
                    end else if (flush && (cnt_q != '0)) begin
                        out_data_q <= res_q;
                        out_cnt_q  <= cnt_q;
                        state_q    <= S_OUT;
                    end
                end
                S_EVAL: begin
                    res_q <= res_d;
                    cnt_q <= cnt_d;
                    if ((y != y_exp) && (err_q != {ERR_W{1'b1}})) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    if (cnt_d == FULL) begin
                        out_data_q <= res_d;
                        out_cnt_q  <= FULL;
                        state_q    <= S_OUT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        res_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign a         = cmd_q.a;
    assign b         = cmd_q.b;
    assign sel       = cmd_q.sel;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign err_cnt   = err_q;

endmodule

// File: doc/fn_sw_seq.md
Name: fn_sw_seq

Overview:
Command sequencer and result packer wrapped around the fn_sw_4 four-function logic unit.
- Accepts 4-bit operand/opcode commands over a valid/ready handshake and drives a, b and sel into fn_sw_4.
- Samples fn_sw_4's y one cycle later and checks it against an internal golden model.
- Packs PACK_W results into a word for a downstream consumer.

Parameters:
PACK_W, 8, results per output word (2..32)
ERR_W, 8, width of saturating mismatch counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  command valid
in_ready  output  1  command accepted when in_valid & in_ready at clk edge
in_absel  input  4  command: bit0=a, bit1=b, bits[3:2]=sel
flush  input  1  pulse: emit partially filled word
a  output  1  operand a to fn_sw_4
b  output  1  operand b to fn_sw_4
sel  output  2  function select to fn_sw_4 (00 AND, 01 OR, 10 XOR, 11 XNOR)
y  input  1  result from fn_sw_4 (combinational from a/b/sel)
out_valid  output  1  packed word valid
out_ready  input  1  consumer accepts word
out_data  output  PACK_W  packed results, first result in bit 0
out_cnt  output  clog2(PACK_W+1)  number of valid bits in out_data
err_cnt  output  ERR_W  saturating count of y mismatches vs golden model

Behaviour:
- Reset (async, rst=1):
  - state=S_IDLE; a=b=0, sel=2'b00.
  - Internal result shift register, bit count, out_data, out_cnt and err_cnt all 0; out_valid=0.
  - Commands and flush are ignored while rst=1.
  - Reset mid-operation discards the partial word and any pending output.
- a, b, sel, out_data, out_cnt and err_cnt are registered. in_ready = (state==S_IDLE), combinational from state.
- S_IDLE:
  - in_valid=1: latch in_absel into a/b/sel and the golden-model operand register; go to S_EVAL.
  - Otherwise, flush=1 and bit count>0: go to S_OUT with out_cnt=count. flush with count=0 is ignored.
  - in_valid and flush in the same cycle: the command wins and flush is dropped; the requester must re-pulse.
- S_EVAL (exactly 1 cycle; a/b/sel stable across it):
  - At the closing edge, y is written into result bit [count] and count increments.
  - If y != golden(a,b,sel), err_cnt increments, saturating at 2^ERR_W-1.
  - If count reaches PACK_W, go to S_OUT with out_cnt=PACK_W; otherwise go to S_IDLE.
- Throughput: one command per 2 cycles. Latency from command accept to y capture: 1 cycle.
- S_OUT:
  - out_valid=1; out_data and out_cnt held stable; bits at and above out_cnt are 0; in_ready=0.
  - On out_ready=1: clear count and shift register, drop out_valid at the same edge, go to S_IDLE.
  - out_ready outside S_OUT has no effect.
- a/b/sel retain the last command between commands; no glitch-to-zero.
- err_cnt is cleared only by reset.

Decomposition:
- Shared package fn_sw_pkg holds:
  - sel encodings FN_AND=2'b00, FN_OR=2'b01, FN_XOR=2'b10, FN_XNOR=2'b11;
  - state encodings S_IDLE, S_EVAL, S_OUT;
  - in_absel field positions.
- One sub-module fn_sw_gold: pure combinational golden model (a, b, sel -> y_exp) built on the package encodings. The sequencer instantiates it; the bench may reuse it.

Test Plan:
1. Reset: assert rst while in S_OUT with out_valid=1 -> out_valid=0, a=b=0, sel=00, err_cnt=0 immediately; in_ready=1 after release.
2. Commands 0..7 back-to-back with out_ready=1 and fn_sw_4 connected -> out_data=8'hE8, out_cnt=8, err_cnt=0; one command accepted every 2 cycles.
3. Commands 8..15 -> out_data=8'h96, out_cnt=8, err_cnt=0.
4. Backpressure: hold out_ready=0 for 5 cycles in S_OUT -> out_valid/out_data/out_cnt stable, in_ready=0, in_valid pulses not accepted; release -> word taken, in_ready=1 next cycle.
5. Flush: commands 0, 3, 5 then flush pulse -> out_data=8'h06, out_cnt=3. Flush with empty buffer -> no out_valid. flush coincident with in_valid -> command accepted, no output.
6. Error injection: bench inverts y for one command -> err_cnt=1, captured bit is the inverted value. 300 forced mismatches -> err_cnt saturates at 255.
